// File: rtl/sampler_trigger_pkg.sv
// Shared types and constants for the sampler trigger block.
//   state_e     : trigger FSM encoding, also exported on the status port.
//   StateWidth  : width of the state encoding.
//   DataLatency : cycles from data_in to data_out.
package sampler_trigger_pkg;

    localparam int unsigned StateWidth  = 2;
    localparam int unsigned DataLatency = 2;

    typedef enum logic [StateWidth-1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StDelay = 2'd2,
        StFired = 2'd3
    } state_e;

endpackage

// File: rtl/sampler_trigger_match.sv
// Sample register plus trigger compare for the sampler trigger.
// Ports:
//   clk, reset  : sample clock, synchronous active-high reset
//   data_i      : raw sample, registered into data_q_o
//   mask_i      : latched compare mask (1 = bit participates)
//   value_i     : latched compare pattern
//   edge_i      : 0 = level match, 1 = non-match to match transition
//   track_i     : update the previous-match flag this cycle (FSM is ARMED)
//   preset_i    : arm accepted; force previous-match high
//   data_q_o    : data_i delayed one cycle
//   hit_o       : trigger condition evaluated on data_q_o
module sampler_trigger_match
    import sampler_trigger_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] mask_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic             edge_i,
    input  logic             track_i,
    input  logic             preset_i,
    output logic [WIDTH-1:0] data_q_o,
    output logic             hit_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             match_prev_q, match_prev_d;
    logic             match;

    assign match = ((data_q ^ value_i) & mask_i) == '0;

    always_comb begin
        data_d       = data_i;
        match_prev_d = match_prev_q;
        // Presetting on arm keeps a pattern already present from firing in edge mode.
        if (preset_i) begin
            match_prev_d = 1'b1;
        end else if (track_i) begin
            match_prev_d = match;
        end
        hit_o = edge_i ? (match & ~match_prev_q) : match;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q       <= '0;
            match_prev_q <= 1'b0;
        end else begin
            data_q       <= data_d;
            match_prev_q <= match_prev_d;
        end
    end

    assign data_q_o = data_q;

endmodule

// File: rtl/sampler_trigger.sv
// Sampler trigger: holds the capture memory in reset until a programmable trigger
// fires (optionally after a post-trigger delay) and retimes the sample stream so the
// triggering word is the first word captured.
// Optional feature macro: TRIGGER_TIMEOUT_EN adds an auto-trigger timeout
// (TIMEOUT_BITS, cfg_timeout, timed_out).
// Ports:
//   clk, reset             : sample clock, synchronous active-high reset
//   data_in / data_out     : probe sample in, same sample DataLatency cycles later
//   cfg_mask/value/edge    : compare setup, latched on arm
//   cfg_delay              : cycles from trigger hit to run, latched on arm
//   arm / disarm           : single-cycle control pulses (disarm wins)
//   run                    : high in FIRED; drives capture memory write reset
//   fired                  : one-cycle pulse on entry to FIRED
//   state                  : current FSM state for the status register
//   cfg_timeout, timed_out : auto-trigger timeout (TRIGGER_TIMEOUT_EN only)
module sampler_trigger
    import sampler_trigger_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
`ifdef TRIGGER_TIMEOUT_EN
    parameter int unsigned TIMEOUT_BITS = 24,
`endif
    parameter int unsigned DELAY_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      data_in,
    output logic [WIDTH-1:0]      data_out,
    input  logic [WIDTH-1:0]      cfg_mask,
    input  logic [WIDTH-1:0]      cfg_value,
    input  logic                  cfg_edge,
    input  logic [DELAY_BITS-1:0] cfg_delay,
    input  logic                  arm,
    input  logic                  disarm,
    output logic                  run,
    output logic                  fired,
`ifdef TRIGGER_TIMEOUT_EN
    input  logic [TIMEOUT_BITS-1:0] cfg_timeout,
    output logic                    timed_out,
`endif
    output logic [StateWidth-1:0] state
);

    localparam int unsigned OutStages = DataLatency - 1;

    state_e                          state_q, state_d;
    logic [WIDTH-1:0]                mask_q, mask_d, value_q, value_d;
    logic                            edge_q, edge_d;
    logic [DELAY_BITS-1:0]           delay_q, delay_d, cnt_q, cnt_d;
    logic                            run_q, run_d, fired_q, fired_d;
    logic [OutStages-1:0][WIDTH-1:0] out_pipe_q, out_pipe_d;
    logic [WIDTH-1:0]                data_q;
    logic                            hit, trig, load_cfg, armed_step;

    assign load_cfg   = arm & ~disarm;
    assign armed_step = (state_q == StArmed) & ~arm & ~disarm;

    sampler_trigger_match #(
        .WIDTH (WIDTH)
    ) u_match (
        .clk      (clk),
        .reset    (reset),
        .data_i   (data_in),
        .mask_i   (mask_q),
        .value_i  (value_q),
        .edge_i   (edge_q),
        .track_i  (state_q == StArmed),
        .preset_i (load_cfg),
        .data_q_o (data_q),
        .hit_o    (hit)
    );

`ifdef TRIGGER_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] timeout_q, timeout_d, to_cnt_q, to_cnt_d;
    logic                    timed_out_q, timed_out_d, force_hit;

    // to_cnt_q holds completed ARMED cycles, so the current cycle is number to_cnt_q + 1.
    assign force_hit = (timeout_q != '0) && (to_cnt_q == timeout_q - TIMEOUT_BITS'(1));
    assign trig      = hit | force_hit;

    always_comb begin
        timeout_d   = load_cfg ? cfg_timeout : timeout_q;
        to_cnt_d    = to_cnt_q;
        timed_out_d = timed_out_q;
        if (load_cfg) begin
            to_cnt_d    = '0;
            timed_out_d = 1'b0;
        end else if (state_q == StArmed) begin
            to_cnt_d = to_cnt_q + TIMEOUT_BITS'(1);
        end
        // A real hit in the timeout cycle takes precedence.
        if (armed_step && force_hit && !hit) begin
            timed_out_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q   <= '0;
            to_cnt_q    <= '0;
            timed_out_q <= 1'b0;
        end else begin
            timeout_q   <= timeout_d;
            to_cnt_q    <= to_cnt_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign timed_out = timed_out_q;
`else
    assign trig = hit;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = load_cfg ? cfg_mask  : mask_q;
        value_d = load_cfg ? cfg_value : value_q;
        edge_d  = load_cfg ? cfg_edge  : edge_q;
        delay_d = load_cfg ? cfg_delay : delay_q;
        if (disarm) begin
            state_d = StIdle;
        end else if (arm) begin
            state_d = StArmed;
        end else begin
            unique case (state_q)
                StIdle: ;
                StArmed: begin
                    if (trig) begin
                        if (delay_q == '0) begin
                            state_d = StFired;
                        end else begin
                            cnt_d   = delay_q;
                            state_d = StDelay;
                        end
                    end
                end
                StDelay: begin
                    cnt_d = cnt_q - DELAY_BITS'(1);
                    if (cnt_q <= DELAY_BITS'(1)) begin
                        state_d = StFired;
                    end
                end
                StFired: ;
                default: state_d = StIdle;
            endcase
        end
        run_d   = (state_d == StFired);
        fired_d = run_d & (state_q != StFired);
        out_pipe_d[0] = data_q;
        for (int i = 1; i < OutStages; i++) begin
            out_pipe_d[i] = out_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mask_q     <= '0;
            value_q    <= '0;
            edge_q     <= 1'b0;
            delay_q    <= '0;
            run_q      <= 1'b0;
            fired_q    <= 1'b0;
            out_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            value_q    <= value_d;
            edge_q     <= edge_d;
            delay_q    <= delay_d;
            run_q      <= run_d;
            fired_q    <= fired_d;
            out_pipe_q <= out_pipe_d;
        end
    end

    assign data_out = out_pipe_q[OutStages-1];
    assign run      = run_q;
    assign fired    = fired_q;
    assign state    = state_q;

endmodule

// File: doc/sampler_trigger.md
Name: sampler_trigger

Overview:
Upstream stage of the capture memory. Watches the incoming sample word and holds the capture memory in reset until a programmable trigger fires, optionally after a post-trigger delay. Produces the run level that drives the capture memory's active-low write reset, plus the sample stream retimed so the triggering word is the first word captured. Lives in the sample clock domain, between the probe inputs and the capture memory.

Parameters:
WIDTH, 32, sample word width in bits; must equal the capture memory's word width.
DELAY_BITS, 16, width of the post-trigger delay counter.
TIMEOUT_BITS, 24, width of the auto-trigger timeout counter; used only with TRIGGER_TIMEOUT_EN.

Ports:
clk  in  1  sample clock.
reset  in  1  synchronous, active-high reset.
data_in  in  WIDTH  raw probe sample, one per cycle.
data_out  out  WIDTH  data_in delayed exactly 2 cycles; connects to the capture memory's sample input.
cfg_mask  in  WIDTH  compare mask; 1 means the bit participates in the compare.
cfg_value  in  WIDTH  compare pattern.
cfg_edge  in  1  0 = level match; 1 = fire only on a non-match to match transition.
cfg_delay  in  DELAY_BITS  cycles from trigger hit to run.
arm  in  1  single-cycle pulse; latches all cfg_* inputs and starts waiting for a trigger.
disarm  in  1  single-cycle pulse; returns to IDLE and drops run.
run  out  1  level, high in FIRED; connects to the capture memory's active-low write reset.
fired  out  1  one-cycle pulse on entry to FIRED.
state  out  2  current state encoding, for the status register.
cfg_timeout  in  TIMEOUT_BITS  present only with TRIGGER_TIMEOUT_EN.
timed_out  out  1  present only with TRIGGER_TIMEOUT_EN.

Behaviour:
- Reset: state=IDLE, run=0, fired=0, data_out=0, all internal registers 0, latched config 0, timed_out=0.
- Data pipeline: data_q <= data_in; data_out <= data_q. The pipeline runs in every state. Reset clears it.
- Match: match = ((data_q ^ value_l) & mask_l) == 0, using the latched config. If mask_l = 0, match is always 1.
- Hit:
  - Level mode (edge_l=0): hit = match.
  - Edge mode (edge_l=1): hit = match & !match_prev, where match_prev <= match each cycle in ARMED.
  - arm sets match_prev=1, so a pattern already present at arm does not fire in edge mode.
- States: IDLE=0, ARMED=1, DELAY=2, FIRED=3.
  - IDLE: on arm, latch cfg_* and go to ARMED.
  - ARMED: on a hit with delay_l=0, go to FIRED. On a hit with delay_l>0, load cnt=delay_l and go to DELAY.
  - DELAY: cnt decrements each cycle. In the cycle with cnt==1, go to FIRED.
  - FIRED: stay until disarm, arm, or reset.
- run is the registered output of (next_state==FIRED), so it rises in the same cycle state becomes FIRED.
- Alignment with delay_l=0: the hit is evaluated on data_q at cycle t; run=1 from t+1. data_out at t+1 is the triggering word, so it is the first word captured.
- Alignment with delay_l=N: run rises at t+1+N.
- fired: 1 for exactly the first cycle of FIRED.
- arm in ARMED, DELAY, or FIRED re-latches config and goes to ARMED. run drops the next cycle, which restarts the capture memory.
- disarm in any state goes to IDLE. arm and disarm in the same cycle: disarm wins.
- Reset mid-DELAY or mid-FIRED: IDLE next cycle and run=0. Reset has priority over arm and disarm.
- cfg_* changes while not arming are ignored.

Optional Feature:
- Macro: TRIGGER_TIMEOUT_EN.
- With the macro defined:
  - cfg_timeout is latched on arm.
  - A counter counts cycles spent in ARMED.
  - If timeout_l != 0 and the count reaches timeout_l with no hit, a forced hit occurs: same path as a real hit, including the delay.
  - timed_out is set on a forced hit and cleared on arm or reset.
  - A real hit and the timeout in the same cycle count as a real hit; timed_out stays 0.
- Without the macro: the cfg_timeout and timed_out ports are absent and there is no timeout logic.

Decomposition:
- Package sampler_trigger_pkg holds:
  - the state enum (IDLE/ARMED/DELAY/FIRED, 2 bits);
  - a localparam for the 2-cycle data latency;
  - the state width constant.
- One sub-module, sampler_trigger_match:
  - registered data_q and match_prev;
  - combinational mask/compare and edge detect;
  - outputs hit and data_q.
- The FSM and counters stay in the top module.

Test Plan:
- Level, delay 0: mask=0xFF, value=0x5A, arm, then data_in ramps 0x00..0xFF → fired 2 cycles after data_in=0x5A; the first data_out with run=1 is 0x5A; state=3.
- Edge mode: arm while data_in is held at 0x5A for 10 cycles, then 0x00, then 0x5A → no fire during the hold; fire 2 cycles after the second 0x5A.
- Delay: cfg_delay=5, level hit at data_in cycle t → run rises at t+7; the first captured word is the sample from t+5.
- Arm and disarm in the same cycle while in FIRED → state=0, run=0 next cycle. A subsequent arm alone → state=1, run stays 0.
- Reset asserted during DELAY with cnt=3 → state=0, run=0, data_out=0 the next cycle. No fired pulse after reset is released.
- TRIGGER_TIMEOUT_EN: cfg_timeout=100, mask matches nothing → forced fire after 100 ARMED cycles with timed_out=1. Repeat with a real hit on cycle 100 → timed_out=0.
